ex_alu_stage: RTL

- Execute stage of the 5-stage MIPS pipeline. It sits directly downstream of the ALU control decoder.
- Consumes the decoder's ALU control code together with the ID/EX operands. Computes the ALU result and registers it, with the forwarded control bits, into the EX/MEM pipeline latch.
- Supports stall (hold), flush (bubble) and a valid bit per instruction.

---
 rtl/ex_alu_stage.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - MIPS execute stage with EX/MEM latch; ALU_MULT_EN adds an iterative multiplier
`ifndef SIZE_ALUCTRLOUT
`define SIZE_ALUCTRLOUT 4
`endif
`ifndef ALUCTRLOUT_ADD
`define ALUCTRLOUT_ADD   5'd0
`define ALUCTRLOUT_ADDI  5'd1
`define ALUCTRLOUT_ADDIU 5'd2
`define ALUCTRLOUT_LW    5'd3
`define ALUCTRLOUT_SW    5'd4
`define ALUCTRLOUT_SUB   5'd5
`define ALUCTRLOUT_BEQ   5'd6
`define ALUCTRLOUT_AND   5'd7
`define ALUCTRLOUT_OR    5'd8
`define ALUCTRLOUT_ORI   5'd9
`define ALUCTRLOUT_XOR   5'd10
`define ALUCTRLOUT_SLT   5'd11
`define ALUCTRLOUT_SLL   5'd12
`define ALUCTRLOUT_SRL   5'd13
`define ALUCTRLOUT_SRA   5'd14
`define ALUCTRLOUT_SLLV  5'd15
`define ALUCTRLOUT_SRLV  5'd16
`define ALUCTRLOUT_SRAV  5'd17
`define ALUCTRLOUT_LUI   5'd18
`endif
`ifdef ALU_MULT_EN
`ifndef ALUCTRLOUT_MULT
`define ALUCTRLOUT_MULT  5'd19
`endif
`endif

module ex_alu_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      in_valid,
    input  logic [`SIZE_ALUCTRLOUT:0] alu_ctrl,
    input  logic [DATA_W-1:0]         op_a,
    input  logic [DATA_W-1:0]         op_b,
    input  logic [4:0]                shamt,
    input  logic [REG_AW-1:0]         rd_i,
    input  logic                      reg_write_i,
    input  logic                      mem_read_i,
    input  logic                      mem_write_i,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         result,
    output logic                      zero,
    output logic                      ovf,
    output logic [REG_AW-1:0]         rd_o,
    output logic                      reg_write_o,
    output logic                      mem_read_o,
    output logic                      mem_write_o,
    output logic                      busy_o
);
    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] sum, diff, alu_res;
    logic              add_ovf, sub_ovf, ovf_c, known;
    logic              hold, mul_start, mul_done;
    logic [DATA_W-1:0] mul_res;
    logic              mul_zero, mul_rw, mul_mr, mul_mw;
    logic [REG_AW-1:0] mul_rd;

    assign sum     = op_a + op_b;
    assign diff    = op_a - op_b;
    assign add_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
    assign sub_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
    assign hold    = stall_i | busy_o;

    always_comb begin
        alu_res = '0;
        ovf_c   = 1'b0;
        known   = 1'b1;
        case (alu_ctrl)
            `ALUCTRLOUT_ADD, `ALUCTRLOUT_ADDI: begin
                alu_res = sum;
                ovf_c   = add_ovf;
            end
            `ALUCTRLOUT_ADDIU, `ALUCTRLOUT_LW, `ALUCTRLOUT_SW: alu_res = sum;
            `ALUCTRLOUT_SUB: begin
                alu_res = diff;
                ovf_c   = sub_ovf;
            end
            `ALUCTRLOUT_BEQ:                  alu_res = diff;
            `ALUCTRLOUT_AND:                  alu_res = op_a & op_b;
            `ALUCTRLOUT_OR, `ALUCTRLOUT_ORI:  alu_res = op_a | op_b;
            `ALUCTRLOUT_XOR:                  alu_res = op_a ^ op_b;
            `ALUCTRLOUT_SLT:                  alu_res[0] = $signed(op_a) < $signed(op_b);
            `ALUCTRLOUT_SLL:                  alu_res = op_b << shamt;
            `ALUCTRLOUT_SRL:                  alu_res = op_b >> shamt;
            `ALUCTRLOUT_SRA:                  alu_res = $signed(op_b) >>> shamt;
            `ALUCTRLOUT_SLLV:                 alu_res = op_b << op_a[4:0];
            `ALUCTRLOUT_SRLV:                 alu_res = op_b >> op_a[4:0];
            `ALUCTRLOUT_SRAV:                 alu_res = $signed(op_b) >>> op_a[4:0];
            `ALUCTRLOUT_LUI:                  alu_res = {op_b[DATA_W-17:0], 16'h0000};
            default:                          known = 1'b0;
        endcase
    end

`ifdef ALU_MULT_EN
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t            state, state_nxt;
    logic [4:0]        cnt;
    logic [DATA_W-1:0] ma, mb, prod, prod_step;

    // Partial product including the bit selected by the current counter value
    assign prod_step = prod + (mb[cnt] ? (ma << cnt) : '0);
    assign busy_o    = (state == MUL);
    assign mul_start = (state != MUL) && !flush_i && !stall_i && in_valid
                       && (alu_ctrl == `ALUCTRLOUT_MULT);
    assign mul_done  = (state == MUL) && !flush_i && !stall_i && (cnt == 5'd31);
    assign mul_res   = prod_step;
    assign mul_zero  = (ma == mb);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_start) state_nxt = MUL;
            MUL:     if (flush_i) state_nxt = IDLE;
                     else if (mul_done) state_nxt = DONE;
            DONE:    if (flush_i) state_nxt = IDLE;
                     else if (!stall_i) state_nxt = mul_start ? MUL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            ma     <= '0;
            mb     <= '0;
            prod   <= '0;
            mul_rd <= '0;
            mul_rw <= 1'b0;
            mul_mr <= 1'b0;
            mul_mw <= 1'b0;
        end else if (mul_start) begin
            cnt    <= '0;
            ma     <= op_a;
            mb     <= op_b;
            prod   <= '0;
            mul_rd <= rd_i;
            mul_rw <= reg_write_i;
            mul_mr <= mem_read_i;
            mul_mw <= mem_write_i;
        end else if (state == MUL && !stall_i && !flush_i) begin
            prod <= prod_step;
            cnt  <= cnt + 5'd1;
        end
    end
`else
    assign busy_o    = 1'b0;
    assign mul_start = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_res   = '0;
    assign mul_zero  = 1'b0;
    assign mul_rd    = '0;
    assign mul_rw    = 1'b0;
    assign mul_mr    = 1'b0;
    assign mul_mw    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            ovf         <= 1'b0;
            rd_o        <= '0;
            reg_write_o <= 1'b0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
        end else if (flush_i) begin
            out_valid   <= 1'b0;
            ovf         <= 1'b0;
            reg_write_o <= 1'b0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
        end else if (mul_done) begin
            out_valid   <= 1'b1;
            result      <= mul_res;
            zero        <= mul_zero;
            ovf         <= 1'b0;
            rd_o        <= mul_rd;
            reg_write_o <= mul_rw;
            mem_read_o  <= mul_mr;
            mem_write_o <= mul_mw;
        end else if (!hold) begin
            if (mul_start) begin
                out_valid   <= 1'b0;
                ovf         <= 1'b0;
                reg_write_o <= 1'b0;
                mem_read_o  <= 1'b0;
                mem_write_o <= 1'b0;
            end else begin
                out_valid   <= in_valid;
                result      <= alu_res;
                zero        <= (diff == '0);
                ovf         <= ovf_c;
                rd_o        <= rd_i;
                reg_write_o <= in_valid & known & reg_write_i & ~ovf_c;
                mem_read_o  <= in_valid & known & mem_read_i;
                mem_write_o <= in_valid & known & mem_write_i;
            end
        end
    end
endmodule
